// File: rtl/scratchpad_backdoor_responder.sv
// Backdoor read/write responder in front of the scratchpad SRAM, arbitrating against the functional port.
// Optional SCRATCHPAD_BACKDOOR_TRACE_EN adds completed-write/read counters.
module scratchpad_backdoor_responder #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 64,
    parameter int MEM_BYTES    = 65536,
    parameter int RD_LATENCY   = 1,
    parameter int STARVE_LIMIT = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  bd_req_valid,
    output logic                  bd_req_ready,
    input  logic                  bd_req_we,
    input  logic [ADDR_WIDTH-1:0] bd_req_addr,
    input  logic [DATA_WIDTH-1:0] bd_req_wdata,
    output logic                  bd_rsp_valid,
    input  logic                  bd_rsp_ready,
    output logic [DATA_WIDTH-1:0] bd_rsp_rdata,
    output logic                  bd_rsp_err,
    input  logic                  fn_req,
    output logic                  fn_gnt,
    input  logic                  fn_we,
    input  logic [ADDR_WIDTH-1:0] fn_addr,
    input  logic [DATA_WIDTH-1:0] fn_wdata,
    input  logic [DATA_WIDTH-1:0] fn_mask,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [DATA_WIDTH-1:0] mem_mask,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [31:0]           bd_wr_count,
    output logic [31:0]           bd_rd_count
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RWAIT, S_RESP} state_t;

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    state_t                r_state;
    logic                  r_req_ready;
    logic                  r_rsp_valid;
    logic                  r_rsp_err;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [SW-1:0]         r_starve;
    logic [2:0]            r_lat;

    logic w_bd_slot;
    logic w_cmd_err;

    // Backdoor takes the SRAM when functional side is quiet or has starved us long enough.
    assign w_bd_slot = (r_state == S_ISSUE) &&
                       (!fn_req || (r_starve == SW'(STARVE_LIMIT)));
    assign w_cmd_err = (|bd_req_addr[2:0]) ||
                       ({1'b0, bd_req_addr} >= (ADDR_WIDTH+1)'(MEM_BYTES));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_starve    <= '0;
            r_lat       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_req_ready <= 1'b1;
                    if (bd_req_valid && r_req_ready) begin
                        r_req_ready <= 1'b0;
                        r_we        <= bd_req_we;
                        r_addr      <= bd_req_addr;
                        r_wdata     <= bd_req_wdata;
                        if (w_cmd_err) begin
                            r_rsp_err   <= 1'b1;
                            r_rsp_rdata <= '0;
                            r_rsp_valid <= 1'b1;
                            r_state     <= S_RESP;
                        end else begin
                            r_state <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (w_bd_slot) begin
                        r_starve <= '0;
                        if (r_we) begin
                            r_rsp_err   <= 1'b0;
                            r_rsp_rdata <= '0;
                            r_rsp_valid <= 1'b1;
                            r_state     <= S_RESP;
                        end else begin
                            r_lat   <= 3'd1;
                            r_state <= S_RWAIT;
                        end
                    end else if (r_starve != SW'(STARVE_LIMIT)) begin
                        r_starve <= r_starve + 1'b1;
                    end
                end
                S_RWAIT: begin
                    // r_lat counts cycles since the issue cycle; SRAM data is valid when it hits RD_LATENCY.
                    if (r_lat == 3'(RD_LATENCY)) begin
                        r_rsp_rdata <= mem_rdata;
                        r_rsp_err   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_lat <= r_lat + 1'b1;
                    end
                end
                S_RESP: begin
                    if (bd_rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_err   <= 1'b0;
                        r_rsp_rdata <= '0;
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        mem_req   = fn_req;
        mem_we    = fn_we;
        mem_addr  = fn_addr;
        mem_wdata = fn_wdata;
        mem_mask  = fn_mask;
        if (w_bd_slot) begin
            mem_req   = 1'b1;
            mem_we    = r_we;
            mem_addr  = r_addr;
            mem_wdata = r_wdata;
            mem_mask  = '1;
        end
    end

    assign fn_gnt       = fn_req & ~w_bd_slot;
    assign bd_req_ready = r_req_ready;
    assign bd_rsp_valid = r_rsp_valid;
    assign bd_rsp_err   = r_rsp_err;
    assign bd_rsp_rdata = r_rsp_rdata;

`ifdef SCRATCHPAD_BACKDOOR_TRACE_EN
    logic [31:0] r_wr_cnt;
    logic [31:0] r_rd_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_cnt <= '0;
            r_rd_cnt <= '0;
        end else if ((r_state == S_RESP) && bd_rsp_ready && !r_rsp_err) begin
            if (r_we) r_wr_cnt <= r_wr_cnt + 1'b1;
            else      r_rd_cnt <= r_rd_cnt + 1'b1;
        end
    end

    assign bd_wr_count = r_wr_cnt;
    assign bd_rd_count = r_rd_cnt;
`else
    assign bd_wr_count = '0;
    assign bd_rd_count = '0;
`endif

endmodule

// File: tb/tb_scratchpad_backdoor_responder.sv
// Directed + randomized bench for scratchpad_backdoor_responder with a behavioural SRAM and memory model.
module tb_scratchpad_backdoor_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        bd_req_valid, bd_req_ready, bd_req_we;
    logic [31:0] bd_req_addr;
    logic [63:0] bd_req_wdata;
    logic        bd_rsp_valid, bd_rsp_ready, bd_rsp_err;
    logic [63:0] bd_rsp_rdata;
    logic        fn_req, fn_gnt, fn_we;
    logic [31:0] fn_addr;
    logic [63:0] fn_wdata, fn_mask;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [63:0] mem_wdata, mem_mask, mem_rdata;
    logic [31:0] bd_wr_count, bd_rd_count;

    scratchpad_backdoor_responder dut (
        .clk(clk), .rst_n(rst_n),
        .bd_req_valid(bd_req_valid), .bd_req_ready(bd_req_ready), .bd_req_we(bd_req_we),
        .bd_req_addr(bd_req_addr), .bd_req_wdata(bd_req_wdata),
        .bd_rsp_valid(bd_rsp_valid), .bd_rsp_ready(bd_rsp_ready),
        .bd_rsp_rdata(bd_rsp_rdata), .bd_rsp_err(bd_rsp_err),
        .fn_req(fn_req), .fn_gnt(fn_gnt), .fn_we(fn_we), .fn_addr(fn_addr),
        .fn_wdata(fn_wdata), .fn_mask(fn_mask),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_mask(mem_mask), .mem_rdata(mem_rdata),
        .bd_wr_count(bd_wr_count), .bd_rd_count(bd_rd_count)
    );

    always #5 clk = ~clk;

    // SRAM macro model, 1-cycle read latency, bit-masked writes.
    bit [63:0] sram [0:8191];
    always @(posedge clk) begin
        if (mem_req) begin
            if (mem_we) sram[mem_addr[15:3]] <= (sram[mem_addr[15:3]] & ~mem_mask) | (mem_wdata & mem_mask);
            else        mem_rdata <= sram[mem_addr[15:3]];
        end
    end

    // Bus observer: backdoor-owned cycles are mem_req without a functional grant.
    logic        in_flight = 1'b0;
    int          bd_slots, gnt_run, gnt_at_hold, holds;
    logic        cap_we;
    logic [31:0] cap_addr;
    logic [63:0] cap_mask, cap_wdata;
    always @(negedge clk) begin
        if (rst_n && mem_req && !fn_gnt) begin
            bd_slots  <= bd_slots + 1;
            cap_we    <= mem_we;
            cap_addr  <= mem_addr;
            cap_mask  <= mem_mask;
            cap_wdata <= mem_wdata;
        end
        if (in_flight && fn_req) begin
            if (fn_gnt) gnt_run <= gnt_run + 1;
            else begin
                gnt_at_hold <= gnt_run;
                holds       <= holds + 1;
            end
        end
    end

    int errors = 0;
    int checks = 0;
    logic [63:0] ref_mem [int];

    function automatic logic [63:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 64'h0;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge after the response handshake.
    task automatic bd_txn(input logic we, input logic [31:0] a, input logic [63:0] wd,
                          input int hold, input logic [63:0] exp_rd,
                          output logic [63:0] rd, output logic er, output int lat);
        int n;
        rd = '0; er = 1'b0; lat = -1;
        bd_req_valid = 1'b1; bd_req_we = we; bd_req_addr = a; bd_req_wdata = wd;
        n = 0;
        while (!bd_req_ready && n < 100) begin @(negedge clk); n++; end
        if (!bd_req_ready) begin
            chk("req_ready_timeout", 64'd0, 64'd1);
            bd_req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        in_flight = 1'b1;
        @(negedge clk);
        bd_req_valid = 1'b0;
        n = 1;
        while (!bd_rsp_valid && n < 200) begin @(negedge clk); n++; end
        in_flight = 1'b0;
        if (!bd_rsp_valid) begin
            chk("rsp_valid_timeout", 64'd0, 64'd1);
            return;
        end
        lat = n;
        for (int k = 0; k < hold; k++) begin
            chk("hold_valid", {63'd0, bd_rsp_valid}, 64'd1);
            chk("hold_rdata", bd_rsp_rdata, exp_rd);
            @(negedge clk);
        end
        rd = bd_rsp_rdata; er = bd_rsp_err;
        bd_rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bd_rsp_ready = 1'b0;
    endtask

    initial begin
        logic [63:0] rd, exp;
        logic        er, we, bad;
        logic [31:0] a;
        int          lat, s0, g0, h0, anyv;

        rst_n = 1'b0; bd_req_valid = 1'b0; bd_req_we = 1'b0; bd_req_addr = '0; bd_req_wdata = '0;
        bd_rsp_ready = 1'b0; fn_req = 1'b0; fn_we = 1'b0; fn_addr = '0; fn_wdata = '0; fn_mask = '0;
        repeat (3) @(negedge clk);

        chk("rst_rsp_valid", {63'd0, bd_rsp_valid}, 64'd0);
        chk("rst_rsp_err",   {63'd0, bd_rsp_err},   64'd0);
        chk("rst_rsp_rdata", bd_rsp_rdata, 64'd0);
        chk("rst_req_ready", {63'd0, bd_req_ready}, 64'd0);
        chk("rst_mem_req",   {63'd0, mem_req},      64'd0);
        chk("rst_counts",    {bd_wr_count, bd_rd_count}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", {63'd0, bd_req_ready}, 64'd1);

        // Uncontended write then read-back.
        bd_txn(1'b1, 32'h100, 64'hDEADBEEF_CAFEF00D, 0, 64'd0, rd, er, lat);
        ref_mem[32'h100] = 64'hDEADBEEF_CAFEF00D;
        #1;
        chk("wr_latency", 64'(lat), 64'd2);
        chk("wr_err", {63'd0, er}, 64'd0);
        chk("wr_rdata", rd, 64'd0);
        chk("wr_mem_we", {63'd0, cap_we}, 64'd1);
        chk("wr_mem_addr", {32'd0, cap_addr}, 64'h100);
        chk("wr_mem_mask", cap_mask, '1);
        chk("wr_mem_wdata", cap_wdata, 64'hDEADBEEF_CAFEF00D);
        @(negedge clk);
        bd_txn(1'b0, 32'h100, 64'd0, 0, 64'd0, rd, er, lat);
        chk("rd_latency", 64'(lat), 64'd3);
        chk("rd_data", rd, 64'hDEADBEEF_CAFEF00D);
        chk("rd_err", {63'd0, er}, 64'd0);

        // Functional traffic saturating the port: backdoor waits STARVE_LIMIT grants, then steals one slot.
        fn_req = 1'b1; fn_we = 1'b0; fn_addr = 32'h200;
        #1; g0 = gnt_run; h0 = holds;
        bd_txn(1'b0, 32'h100, 64'd0, 0, 64'd0, rd, er, lat);
        #1;
        chk("starve_grants", 64'(gnt_at_hold - g0), 64'd15);
        chk("starve_holds", 64'(holds - h0), 64'd1);
        chk("starve_slot_addr", {32'd0, cap_addr}, 64'h100);
        chk("starve_rd_data", rd, 64'hDEADBEEF_CAFEF00D);
        chk("starve_latency", 64'(lat), 64'd18);
        chk("fn_resumes", {63'd0, fn_gnt}, 64'd1);

        // Functional masked write passes straight through while idle.
        fn_we = 1'b1; fn_addr = 32'h8000; fn_wdata = 64'h11112222_33334444; fn_mask = 64'hFFFFFFFF_00000000;
        #1;
        chk("fn_gnt_idle", {63'd0, fn_gnt}, 64'd1);
        chk("fn_pass", {mem_req, mem_we, 30'd0, mem_addr}, {2'b11, 30'd0, 32'h8000});
        chk("fn_pass_mask", mem_mask, 64'hFFFFFFFF_00000000);
        chk("fn_pass_wdata", mem_wdata, 64'h11112222_33334444);
        ref_mem[32'h8000] = 64'h11112222_00000000;
        @(negedge clk);
        fn_req = 1'b0; fn_we = 1'b0; fn_mask = '0;
        bd_txn(1'b0, 32'h8000, 64'd0, 0, 64'd0, rd, er, lat);
        chk("fn_masked_rd", rd, 64'h11112222_00000000);

        // Error commands never reach the SRAM.
        #1; s0 = bd_slots;
        bd_txn(1'b0, 32'h104, 64'd0, 0, 64'd0, rd, er, lat);
        chk("misalign_err", {63'd0, er}, 64'd1);
        chk("misalign_rdata", rd, 64'd0);
        bd_txn(1'b1, 32'd65536, 64'h55, 0, 64'd0, rd, er, lat);
        chk("oor_err", {63'd0, er}, 64'd1);
        chk("oor_rdata", rd, 64'd0);
        #1;
        chk("err_no_mem_req", 64'(bd_slots - s0), 64'd0);

        // Randomized traffic against the reference memory.
        for (int i = 0; i < 40; i++) begin
            int kind;
            kind = int'($urandom_range(0, 9));
            we = 1'($urandom_range(0, 1));
            a = {21'd0, 8'($urandom_range(0, 63)), 3'd0};
            if (kind == 0) a = a | 32'($urandom_range(1, 7));
            if (kind == 1) a = 32'd65536 + {16'($urandom), 3'd0};
            bad = (a[2:0] != 3'd0) || (a >= 32'd65536);
            exp = (bad || we) ? 64'd0 : ref_rd(a);
            fn_req = 1'($urandom_range(0, 1));
            fn_we = 1'b0;
            fn_addr = {16'd0, 13'($urandom), 3'd0};
            rd = {$urandom, $urandom};
            bd_txn(we, a, rd, int'($urandom_range(0, 3)), exp, rd, er, lat);
            chk("rand_err", {63'd0, er}, {63'd0, bad});
            chk("rand_rdata", rd, exp);
            if (!bad && we) ref_mem[int'(a)] = bd_req_wdata;
        end
        fn_req = 1'b0;
        @(negedge clk);

        // Backpressure on the response, then reset in the middle of a read.
        bd_txn(1'b0, 32'h100, 64'd0, 5, 64'hDEADBEEF_CAFEF00D, rd, er, lat);
        chk("bp_rdata", rd, ref_rd(32'h100));
        bd_req_valid = 1'b1; bd_req_we = 1'b0; bd_req_addr = 32'h100;
        @(posedge clk);
        @(negedge clk);
        bd_req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_rsp_valid", {63'd0, bd_rsp_valid}, 64'd0);
        chk("midrst_rsp_rdata", bd_rsp_rdata, 64'd0);
        chk("midrst_ready", {63'd0, bd_req_ready}, 64'd0);
        chk("midrst_mem_req", {63'd0, mem_req}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        anyv = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (bd_rsp_valid) anyv++;
        end
        chk("midrst_ready_after", {63'd0, bd_req_ready}, 64'd1);
        chk("midrst_no_stale_rsp", 64'(anyv), 64'd0);
        chk("midrst_counts", {bd_wr_count, bd_rd_count}, 64'd0);

        // 3 writes + 2 reads + 1 error for the trace counters.
        for (int k = 0; k < 3; k++) begin
            bd_txn(1'b1, 32'h400 + 32'(k * 8), 64'(k + 7), 0, 64'd0, rd, er, lat);
            ref_mem[32'h400 + k * 8] = 64'(k + 7);
        end
        bd_txn(1'b0, 32'h400, 64'd0, 0, 64'd0, rd, er, lat);
        chk("trace_rd0", rd, 64'd7);
        bd_txn(1'b0, 32'h410, 64'd0, 0, 64'd0, rd, er, lat);
        chk("trace_rd1", rd, 64'd9);
        bd_txn(1'b1, 32'h403, 64'd1, 0, 64'd0, rd, er, lat);
        chk("trace_err", {63'd0, er}, 64'd1);
`ifdef SCRATCHPAD_BACKDOOR_TRACE_EN
        chk("wr_count", {32'd0, bd_wr_count}, 64'd3);
        chk("rd_count", {32'd0, bd_rd_count}, 64'd2);
`else
        chk("wr_count_off", {32'd0, bd_wr_count}, 64'd0);
        chk("rd_count_off", {32'd0, bd_rd_count}, 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: got stuck want done");
        $fatal(1, "bench timeout");
    end

endmodule
